spi_ram_ctrl: RTL and testbench
===============================

Name: spi_ram_ctrl

Overview:
- Downstream consumer of the SPI slave's parallel output. Receives 10-bit rx_data_s words (control_e + payload) qualified by rx_valid.
- Executes each word against a single-port MEM_DEPTH x MEM_WIDTH memory.
- Returns read data on dout/tx_valid for the slave to shift out on MISO.
- Adds auto-incrementing address pointers and a sequencing-error flag, so multi-byte bursts need only one address command.

Parameters:
- MEM_DEPTH, 256, number of memory words.
- ADDR_SIZE, 8, pointer width; must be <= MEM_WIDTH.
- MEM_WIDTH, 8, data width; din is MEM_WIDTH+2 bits.

Ports:
- clk  in  1  single clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- din  in  MEM_WIDTH+2  rx_data_s: [MEM_WIDTH+1:MEM_WIDTH]=control_e, [MEM_WIDTH-1:0]=payload.
- rx_valid  in  1  din qualifier; one command per cycle when high.
- dout  out  MEM_WIDTH  read data, registered.
- tx_valid  out  1  one-cycle pulse: dout holds fresh read data.
- seq_err  out  1  one-cycle pulse: data command issued with no valid pointer.

Behaviour:
- Reset (rst=1 at an edge):
  - dout=0, tx_valid=0, seq_err=0.
  - wr_ptr=0, rd_ptr=0, wr_vld=0, rd_vld=0.
  - Memory contents are not reset and are retained.
  - rst has priority over rx_valid.
- rx_valid=0: no state change except the tx_valid and seq_err pulses clearing to 0; dout holds its value; din is ignored.
- rx_valid=1, decode din.control:
  - WR_ADDR: wr_ptr <= payload[ADDR_SIZE-1:0]; wr_vld <= 1.
  - WR_DATA, wr_vld=1: mem[wr_ptr] <= payload; wr_ptr <= wr_ptr+1.
  - WR_DATA, wr_vld=0: no write; seq_err=1 next cycle.
  - RD_ADDR: rd_ptr <= payload[ADDR_SIZE-1:0]; rd_vld <= 1; no output.
  - RD_DATA, rd_vld=1: dout <= mem[rd_ptr]; tx_valid <= 1; rd_ptr <= rd_ptr+1.
  - RD_DATA, rd_vld=0: seq_err <= 1; dout unchanged; tx_valid stays 0.
- Latency:
  - RD_DATA sampled at edge k gives dout/tx_valid valid in cycle k..k+1.
  - tx_valid deasserts at edge k+1 unless a new RD_DATA is sampled there.
  - Back-to-back RD_DATA gives continuous tx_valid with successive words.
- Pointer arithmetic:
  - Increment modulo MEM_DEPTH: wraps MEM_DEPTH-1 -> 0.
  - Payload bits above ADDR_SIZE are ignored for addresses.
- Read-after-write:
  - WR_DATA at edge k, RD_DATA to the same address at edge k+1 returns the new data. The write is committed at edge k.
  - Same-cycle conflict is impossible: one command per cycle.
- Reset mid-burst:
  - Clears both valid flags, so the next data command without a new address gives seq_err.
  - Previously written memory stays readable after re-addressing.
- Pointers are independent: write bursts do not disturb rd_ptr, and vice versa.
- Controller has no internal FSM beyond the flags. The protocol state machine (IDLE/CHK_CMD/WRITE/READ_ADD/READ_DATA) lives in the slave. This block must accept any legal command order.

Decomposition:
- shared_pkg holds control_e, rx_data_s, MEM_DEPTH/ADDR_SIZE/MEM_WIDTH.
- shared_pkg gains ZERO-based reset constants for dout.
- Casting din to rx_data_s is required; no literal control encodings in RTL.
- One sub-module: spi_ram_array.
  - Synchronous write, synchronous registered read.
  - Ports: clk, we, waddr, wdata, re, raddr, rdata.
  - No reset on the storage.
- Pointers, flags, and the tx_valid/seq_err pulses sit in spi_ram_ctrl.

Test Plan:
- Burst write and read back: after reset, WR_ADDR 0x12, WR_DATA 0xA5, WR_DATA 0x5A, RD_ADDR 0x12, RD_DATA x2 -> dout 0xA5 then 0x5A, tx_valid high for exactly 2 consecutive cycles.
- Pointer wrap: WR_ADDR 0xFF, WR_DATA 0x11, WR_DATA 0x22, RD_ADDR 0xFF, RD_DATA x2 -> 0x11 then 0x22, the second word read from addr 0x00.
- Sequencing error: reset, then RD_DATA -> seq_err=1 for one cycle, tx_valid=0, dout=0x00. Reset, then WR_DATA 0x77, WR_ADDR 0x05, RD_ADDR 0x05, RD_DATA -> mem[5] unchanged (no write occurred) and seq_err pulsed once.
- Reset mid-burst: WR_ADDR 0x30, WR_DATA 0xC3, rst one cycle, WR_DATA 0x3C -> seq_err pulse. Then RD_ADDR 0x30, RD_DATA -> 0xC3 (memory retained).
- Read-after-write and idle filtering: WR_ADDR 0x40, WR_DATA 0x99, immediately RD_ADDR 0x40, RD_DATA -> 0x99. Driving din=ALT_10_RX_DATA with rx_valid=0 for 10 cycles -> no write, no tx_valid, no seq_err, pointers unchanged.

Source files
------------

// File: rtl/shared_pkg.sv
// Shared types and constants for the SPI RAM controller: command encoding,
// received-word layout and memory geometry.
package shared_pkg;

    localparam int MEM_DEPTH = 256;
    localparam int ADDR_SIZE = 8;
    localparam int MEM_WIDTH = 8;

    typedef enum logic [1:0] {
        WR_ADDR = 2'b00,
        WR_DATA = 2'b01,
        RD_ADDR = 2'b10,
        RD_DATA = 2'b11
    } control_e;

    typedef struct packed {
        control_e               control;
        logic [MEM_WIDTH-1:0]   payload;
    } rx_data_s;

    localparam logic [MEM_WIDTH-1:0] DOUT_RST = {MEM_WIDTH{1'b0}};

endpackage

// File: rtl/spi_ram_array.sv
// Single-port storage with synchronous write and registered synchronous read.
// Contents and read register are deliberately left unreset.
module spi_ram_array #(
    parameter int MEM_DEPTH = shared_pkg::MEM_DEPTH,
    parameter int MEM_WIDTH = shared_pkg::MEM_WIDTH,
    parameter int ADDR_SIZE = shared_pkg::ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_SIZE-1:0] waddr,
    input  logic [MEM_WIDTH-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_SIZE-1:0] raddr,
    output logic [MEM_WIDTH-1:0] rdata
);

    logic [MEM_WIDTH-1:0] mem_r [MEM_DEPTH];

    // Storage write port and registered read port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem_r[raddr];
        end
    end

endmodule

// File: rtl/spi_ram_ctrl.sv
// Executes SPI-slave command words against a local RAM, with auto-incrementing
// read/write pointers and a pulse flagging data commands that lack an address.
module spi_ram_ctrl #(
    parameter int MEM_DEPTH = shared_pkg::MEM_DEPTH,
    parameter int ADDR_SIZE = shared_pkg::ADDR_SIZE,
    parameter int MEM_WIDTH = shared_pkg::MEM_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [MEM_WIDTH+1:0] din,
    input  logic                 rx_valid,
    output logic [MEM_WIDTH-1:0] dout,
    output logic                 tx_valid,
    output logic                 seq_err
);
    import shared_pkg::*;

    rx_data_s               cmd_s;
    logic [ADDR_SIZE-1:0]   wr_ptr_r, wr_ptr_nxt_s;
    logic [ADDR_SIZE-1:0]   rd_ptr_r, rd_ptr_nxt_s;
    logic                   wr_vld_r, wr_vld_nxt_s;
    logic                   rd_vld_r, rd_vld_nxt_s;
    logic                   we_s, re_s;
    logic                   tx_valid_r, tx_valid_nxt_s;
    logic                   seq_err_r, seq_err_nxt_s;
    logic                   dout_clr_r;
    logic [MEM_WIDTH-1:0]   rdata_s;

    // Wrap at MEM_DEPTH so non-power-of-two depths stay in range
    function automatic logic [ADDR_SIZE-1:0] ptr_inc(input logic [ADDR_SIZE-1:0] p);
        logic [ADDR_SIZE-1:0] nxt;
        if (p == ADDR_SIZE'(MEM_DEPTH - 1)) begin
            nxt = {ADDR_SIZE{1'b0}};
        end else begin
            nxt = p + {{(ADDR_SIZE-1){1'b0}}, 1'b1};
        end
        return nxt;
    endfunction

    assign cmd_s = rx_data_s'(din);

    // Command decode; reset suppresses any memory access in the same cycle
    always_comb begin
        wr_ptr_nxt_s   = wr_ptr_r;
        wr_vld_nxt_s   = wr_vld_r;
        rd_ptr_nxt_s   = rd_ptr_r;
        rd_vld_nxt_s   = rd_vld_r;
        we_s           = 1'b0;
        re_s           = 1'b0;
        tx_valid_nxt_s = 1'b0;
        seq_err_nxt_s  = 1'b0;
        if (rx_valid && !rst) begin
            case (cmd_s.control)
                WR_ADDR: begin
                    wr_ptr_nxt_s = cmd_s.payload[ADDR_SIZE-1:0];
                    wr_vld_nxt_s = 1'b1;
                end
                WR_DATA: begin
                    if (wr_vld_r) begin
                        we_s         = 1'b1;
                        wr_ptr_nxt_s = ptr_inc(wr_ptr_r);
                    end else begin
                        seq_err_nxt_s = 1'b1;
                    end
                end
                RD_ADDR: begin
                    rd_ptr_nxt_s = cmd_s.payload[ADDR_SIZE-1:0];
                    rd_vld_nxt_s = 1'b1;
                end
                RD_DATA: begin
                    if (rd_vld_r) begin
                        re_s           = 1'b1;
                        tx_valid_nxt_s = 1'b1;
                        rd_ptr_nxt_s   = ptr_inc(rd_ptr_r);
                    end else begin
                        seq_err_nxt_s = 1'b1;
                    end
                end
                default: begin
                    seq_err_nxt_s = 1'b0;
                end
            endcase
        end else begin
            we_s = 1'b0;
        end
    end

    // Pointer, flag and pulse registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= {ADDR_SIZE{1'b0}};
            rd_ptr_r   <= {ADDR_SIZE{1'b0}};
            wr_vld_r   <= 1'b0;
            rd_vld_r   <= 1'b0;
            tx_valid_r <= 1'b0;
            seq_err_r  <= 1'b0;
            dout_clr_r <= 1'b1;
        end else begin
            wr_ptr_r   <= wr_ptr_nxt_s;
            rd_ptr_r   <= rd_ptr_nxt_s;
            wr_vld_r   <= wr_vld_nxt_s;
            rd_vld_r   <= rd_vld_nxt_s;
            tx_valid_r <= tx_valid_nxt_s;
            seq_err_r  <= seq_err_nxt_s;
            if (re_s) begin
                dout_clr_r <= 1'b0;
            end
        end
    end

    spi_ram_array #(
        .MEM_DEPTH (MEM_DEPTH),
        .MEM_WIDTH (MEM_WIDTH),
        .ADDR_SIZE (ADDR_SIZE)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .waddr (wr_ptr_r),
        .wdata (cmd_s.payload),
        .re    (re_s),
        .raddr (rd_ptr_r),
        .rdata (rdata_s)
    );

    // The array's read register has no reset, so mask it until the first read
    assign dout     = dout_clr_r ? DOUT_RST : rdata_s;
    assign tx_valid = tx_valid_r;
    assign seq_err  = seq_err_r;

endmodule

// File: tb/tb_spi_ram_ctrl.sv
// Directed bench for spi_ram_ctrl: bursts, pointer wrap, sequencing errors,
// reset mid-burst, read-after-write and idle filtering.
module tb_spi_ram_ctrl;
    import shared_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic       rx_valid;
    logic [7:0] dout;
    logic       tx_valid;
    logic       seq_err;

    int n_cmp = 0;
    int n_err = 0;

    spi_ram_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .din      (din),
        .rx_valid (rx_valid),
        .dout     (dout),
        .tx_valid (tx_valid),
        .seq_err  (seq_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [7:0] e_dout,
                           input logic e_tx, input logic e_err);
        chk({tag, "_dout"}, 32'(dout), 32'(e_dout));
        chk({tag, "_tx"}, 32'(tx_valid), 32'(e_tx));
        chk({tag, "_err"}, 32'(seq_err), 32'(e_err));
    endtask

    // One command, sampled at the next rising edge; outputs observed 1ns later
    task automatic cmd(input control_e c, input logic [7:0] p);
        din      = {2'(c), p};
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        rx_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b0;
        rx_valid = 1'b0;
        din      = 10'd0;
        @(negedge clk);
        do_reset();
        chk_out("reset", 8'h00, 1'b0, 1'b0);

        // Burst write then burst read
        cmd(WR_ADDR, 8'h12);
        cmd(WR_DATA, 8'hA5);
        cmd(WR_DATA, 8'h5A);
        chk_out("wr_quiet", 8'h00, 1'b0, 1'b0);
        cmd(RD_ADDR, 8'h12);
        chk_out("rdaddr_quiet", 8'h00, 1'b0, 1'b0);
        cmd(RD_DATA, 8'h00);
        chk_out("burst_rd0", 8'hA5, 1'b1, 1'b0);
        cmd(RD_DATA, 8'h00);
        chk_out("burst_rd1", 8'h5A, 1'b1, 1'b0);
        idle(1);
        chk_out("burst_end", 8'h5A, 1'b0, 1'b0);

        // Pointer wrap FF -> 00
        cmd(WR_ADDR, 8'hFF);
        cmd(WR_DATA, 8'h11);
        cmd(WR_DATA, 8'h22);
        cmd(RD_ADDR, 8'hFF);
        cmd(RD_DATA, 8'h00);
        chk_out("wrap_rd0", 8'h11, 1'b1, 1'b0);
        cmd(RD_DATA, 8'h00);
        chk_out("wrap_rd1", 8'h22, 1'b1, 1'b0);
        cmd(RD_ADDR, 8'h00);
        cmd(RD_DATA, 8'h00);
        chk_out("wrap_addr0", 8'h22, 1'b1, 1'b0);

        // Read with no pointer after reset
        do_reset();
        chk_out("rst2", 8'h00, 1'b0, 1'b0);
        cmd(RD_DATA, 8'h00);
        chk_out("rd_noptr", 8'h00, 1'b0, 1'b1);
        idle(1);
        chk_out("rd_noptr_end", 8'h00, 1'b0, 1'b0);

        // Write with no pointer must not touch memory
        cmd(WR_ADDR, 8'h05);
        cmd(WR_DATA, 8'hE1);
        do_reset();
        cmd(WR_DATA, 8'h77);
        chk_out("wr_noptr", 8'h00, 1'b0, 1'b1);
        idle(1);
        chk_out("wr_noptr_end", 8'h00, 1'b0, 1'b0);
        cmd(WR_ADDR, 8'h05);
        chk("wr_addr_err", 32'(seq_err), 32'h0);
        cmd(RD_ADDR, 8'h05);
        cmd(RD_DATA, 8'h00);
        chk_out("mem5_kept", 8'hE1, 1'b1, 1'b0);
        cmd(RD_ADDR, 8'h00);
        cmd(RD_DATA, 8'h00);
        chk_out("mem0_kept", 8'h22, 1'b1, 1'b0);

        // Reset mid-burst
        cmd(WR_ADDR, 8'h30);
        cmd(WR_DATA, 8'hC3);
        do_reset();
        chk_out("midrst", 8'h00, 1'b0, 1'b0);
        cmd(WR_DATA, 8'h3C);
        chk_out("midrst_wr", 8'h00, 1'b0, 1'b1);
        cmd(RD_ADDR, 8'h30);
        chk("midrst_rdaddr_err", 32'(seq_err), 32'h0);
        cmd(RD_DATA, 8'h00);
        chk_out("midrst_rd", 8'hC3, 1'b1, 1'b0);

        // Read-after-write on consecutive commands
        cmd(WR_ADDR, 8'h40);
        cmd(WR_DATA, 8'h99);
        cmd(RD_ADDR, 8'h40);
        cmd(RD_DATA, 8'h00);
        chk_out("raw", 8'h99, 1'b1, 1'b0);

        // Idle filtering: din garbage with rx_valid low
        din      = 10'b10_1010_1010;
        rx_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk_out($sformatf("idle%0d", i), 8'h99, 1'b0, 1'b0);
            din = (i % 2 == 0) ? {2'(RD_DATA), 8'h55} : {2'(WR_DATA), 8'hAA};
        end
        // Both pointers should still sit at 0x41 with flags set
        cmd(WR_DATA, 8'h5F);
        chk("post_idle_wr_err", 32'(seq_err), 32'h0);
        cmd(RD_DATA, 8'h00);
        chk_out("post_idle_rd", 8'h5F, 1'b1, 1'b0);
        cmd(RD_ADDR, 8'h40);
        cmd(RD_DATA, 8'h00);
        chk_out("post_idle_40", 8'h99, 1'b1, 1'b0);

        // Reset wins over a concurrent valid command
        din      = {2'(WR_ADDR), 8'h07};
        rx_valid = 1'b1;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        rx_valid = 1'b0;
        cmd(WR_DATA, 8'h12);
        chk_out("rst_prio", 8'h00, 1'b0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
